// File: rtl/axi_pkg.sv
// Shared AXI definitions for the VIP memory model: burst/response encodings and
// the slave channel state machine encoding.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts; shared by
// the write and read slaves.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] beat_bytes;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_addr;

    always_comb begin
        beat_bytes = ADDR_WIDTH'(1) << size;
        size_mask  = beat_bytes - ADDR_WIDTH'(1);
        wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        // INCR steps from the aligned address so an unaligned start lands on the next boundary.
        incr_addr  = (addr & ~size_mask) + beat_bytes;
        wrap_addr  = (addr & ~wrap_mask) | ((addr + beat_bytes) & wrap_mask);
        case (burst)
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = wrap_addr;
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_wr_slave.sv
// AXI write-channel responder: accepts one burst at a time, expands it into
// per-beat SRAM word writes and returns a single B response per burst.
module axi_mem_wr_slave
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int BYTE_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic [3:0]              awcache,
    input  logic [2:0]              awprot,
    input  logic [3:0]              awqos,
    input  logic [3:0]              awregion,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [BYTE_WIDTH*8-1:0] wdata,
    input  logic [BYTE_WIDTH-1:0]   wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [BYTE_WIDTH*8-1:0] mem_wdata,
    output logic [BYTE_WIDTH-1:0]   mem_be
);

    localparam int BYTE_LOG    = $clog2(BYTE_WIDTH);
    localparam int MEM_BYTE_AW = MEM_AW + BYTE_LOG;

    wr_state_e             state_reg;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [7:0]            beat_cnt_reg;
    logic [2:0]            size_reg;
    logic [1:0]            burst_reg;
    logic [1:0]            err_reg;
    logic                  wlast_err_reg;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [1:0]            aw_err;
    logic [7:0]            aw_align_mask;
    logic                  beat;
    logic                  last_beat;
    logic [1:0]            final_resp;

    // Cache/protection/QoS/region sideband carries no meaning for a plain memory.
    logic unused_sideband;
    assign unused_sideband = ^{awcache, awprot, awqos, awregion};

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_reg),
        .size      (size_reg),
        .len       (len_reg),
        .burst     (burst_reg),
        .next_addr (next_addr)
    );

    // Decode error takes precedence over any malformed-burst error.
    always_comb begin
        aw_align_mask = (8'd1 << awsize) - 8'd1;
        aw_err        = OKAY;
        if (awaddr[ADDR_WIDTH-1:MEM_BYTE_AW] != '0) begin
            aw_err = DECERR;
        end else if ((awsize > 3'(BYTE_LOG)) || (awburst == 2'd3) ||
                     ((awburst == WRAP) && !wrap_len_ok(awlen)) ||
                     ((awburst == WRAP) && ((awaddr[7:0] & aw_align_mask) != 8'd0))) begin
            aw_err = SLVERR;
        end
    end

    assign beat      = wvalid && wready;
    assign last_beat = (beat_cnt_reg == len_reg);

    // A misplaced wlast only changes the response; writes already issued stand.
    always_comb begin
        final_resp = err_reg;
        if ((err_reg == OKAY) && (wlast_err_reg || (wlast != last_beat))) begin
            final_resp = SLVERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            id_reg        <= '0;
            addr_reg      <= '0;
            len_reg       <= '0;
            beat_cnt_reg  <= '0;
            size_reg      <= '0;
            burst_reg     <= '0;
            err_reg       <= '0;
            wlast_err_reg <= 1'b0;
            awready       <= 1'b0;
            wready        <= 1'b0;
            bid           <= '0;
            bresp         <= '0;
            bvalid        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (awvalid && awready) begin
                        id_reg        <= awid;
                        addr_reg      <= awaddr;
                        len_reg       <= awlen;
                        size_reg      <= awsize;
                        burst_reg     <= awburst;
                        err_reg       <= aw_err;
                        wlast_err_reg <= 1'b0;
                        beat_cnt_reg  <= '0;
                        awready       <= 1'b0;
                        wready        <= 1'b1;
                        state_reg     <= DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                DATA: begin
                    if (beat) begin
                        mem_we        <= (err_reg == OKAY);
                        mem_addr      <= addr_reg[MEM_BYTE_AW-1:BYTE_LOG];
                        mem_wdata     <= wdata;
                        mem_be        <= wstrb;
                        addr_reg      <= next_addr;
                        beat_cnt_reg  <= beat_cnt_reg + 8'd1;
                        wlast_err_reg <= wlast_err_reg || (wlast != last_beat);
                        if (last_beat) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bid       <= id_reg;
                            bresp     <= final_resp;
                            state_reg <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready   <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_wr_slave.sv
// Randomized self-checking bench for axi_mem_wr_slave against a burst-level
// reference model of the expected SRAM writes and B responses.
module tb_axi_mem_wr_slave;

    localparam int IDW = 16;
    localparam int AW  = 64;
    localparam int BW  = 32;
    localparam int MAW = 10;
    localparam int DW  = BW * 8;
    localparam int BL  = $clog2(BW);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [IDW-1:0] awid = '0;
    logic [AW-1:0]  awaddr = '0;
    logic [7:0]     awlen = '0;
    logic [2:0]     awsize = '0;
    logic [1:0]     awburst = '0;
    logic [3:0]     awcache = 4'h3;
    logic [2:0]     awprot = 3'h2;
    logic [3:0]     awqos = 4'h5;
    logic [3:0]     awregion = 4'h1;
    logic           awvalid = 1'b0;
    logic           awready;
    logic [DW-1:0]  wdata = '0;
    logic [BW-1:0]  wstrb = '0;
    logic           wlast = 1'b0;
    logic           wvalid = 1'b0;
    logic           wready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready = 1'b0;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [BW-1:0]  mem_be;

    always #5 clk = ~clk;

    axi_mem_wr_slave #(
        .ID_WIDTH   (IDW),
        .ADDR_WIDTH (AW),
        .BYTE_WIDTH (BW),
        .MEM_AW     (MAW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .awcache   (awcache),
        .awprot    (awprot),
        .awqos     (awqos),
        .awregion  (awregion),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [DW-1:0] got, logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    typedef struct {
        logic           we;
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [BW-1:0]  be;
    } beat_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
        int             len;
    } desc_t;

    beat_t beat_q[$];
    desc_t desc_q[$];

    // Reference model: byte address of beat i computed directly from the burst rules.
    function automatic logic [63:0] model_addr(logic [63:0] a, int len, int size, int burst, int i);
        logic [63:0] bytes;
        logic [63:0] span;
        logic [63:0] base;
        bytes = 64'd1 << size;
        if (burst == 1) begin
            if (i == 0) return a;
            return (a / bytes) * bytes + 64'(i) * bytes;
        end
        if (burst == 2) begin
            span = 64'(len + 1) * bytes;
            base = (a / span) * span;
            return base + (((a - base) + 64'(i) * bytes) % span);
        end
        return a;
    endfunction

    function automatic logic [MAW-1:0] model_word(logic [63:0] a, int len, int size, int burst, int i);
        return MAW'(model_addr(a, len, size, burst, i) >> BL);
    endfunction

    function automatic logic [1:0] model_err(logic [63:0] a, int len, int size, int burst);
        logic wrap_len_bad;
        wrap_len_bad = !(len == 1 || len == 3 || len == 7 || len == 15);
        if (a >= 64'(1 << MAW) * BW) return 2'd3;
        if (size > BL || burst == 3 || (burst == 2 && wrap_len_bad) ||
            (burst == 2 && (a % (64'd1 << size)) != 0)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int j = 0; j < BW / 4; j++) d[j*32 +: 32] = $urandom;
        return d;
    endfunction

    // Stimulus for the burst currently being driven.
    logic [DW-1:0]  st_data [256];
    logic [BW-1:0]  st_strb [256];
    logic           st_last [256];
    logic [IDW-1:0] cur_id;
    logic [AW-1:0]  cur_addr;
    int             cur_len;
    int             cur_size;
    int             cur_burst;

    // strb_mode: 0 full, 1 random, 2 one-hot walking from lane 0.
    task automatic prep_burst(input logic [IDW-1:0] id, input logic [63:0] a, input int len,
                              input int size, input int burst, input int bad_last,
                              input int strb_mode);
        logic [1:0] err;
        logic       lerr;
        beat_t      b;
        desc_t      d;
        err  = model_err(a, len, size, burst);
        lerr = 1'b0;
        for (int i = 0; i <= len; i++) begin
            st_data[i] = rand_data();
            if (strb_mode == 0) st_strb[i] = '1;
            else if (strb_mode == 1) st_strb[i] = $urandom;
            else st_strb[i] = BW'(1) << i;
            st_last[i] = (i == len);
            if (i == bad_last) st_last[i] = !st_last[i];
            if (st_last[i] != (i == len)) lerr = 1'b1;
            b.we   = (err == 2'd0);
            b.addr = model_word(a, len, size, burst, i);
            b.data = st_data[i];
            b.be   = st_strb[i];
            beat_q.push_back(b);
        end
        d.id   = id;
        d.resp = (err != 2'd0) ? err : (lerr ? 2'd2 : 2'd0);
        d.len  = len;
        desc_q.push_back(d);
        cur_id    = id;
        cur_addr  = a;
        cur_len   = len;
        cur_size  = size;
        cur_burst = burst;
    endtask

    // Driver tasks always resume 1 time unit after a rising edge.
    task automatic drive_aw();
        int   n;
        logic ok;
        n       = 0;
        awid    = cur_id;
        awaddr  = cur_addr;
        awlen   = 8'(cur_len);
        awsize  = 3'(cur_size);
        awburst = 2'(cur_burst);
        awvalid = 1'b1;
        do begin
            @(negedge clk);
            ok = awready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        chk("aw_handshake", ok, 1'b1);
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input int first, input int count, input bit gaps);
        int   n;
        logic ok;
        for (int i = first; i < first + count; i++) begin
            if (gaps) begin
                wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            wvalid = 1'b1;
            wdata  = st_data[i];
            wstrb  = st_strb[i];
            wlast  = st_last[i];
            n = 0;
            do begin
                @(negedge clk);
                ok = wready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 200);
            chk("w_handshake", ok, 1'b1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic drive_b(input int delay);
        int   n;
        logic ok;
        bready = 1'b0;
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        bready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = bvalid;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        chk("b_handshake", ok, 1'b1);
        bready = 1'b0;
    endtask

    task automatic run_burst(input logic [IDW-1:0] id, input logic [63:0] a, input int len,
                             input int size, input int burst, input int bad_last,
                             input int strb_mode, input bit gaps, input int bdelay);
        prep_burst(id, a, len, size, burst, bad_last, strb_mode);
        drive_aw();
        drive_w(0, len + 1, gaps);
        drive_b(bdelay);
    endtask

    // Compare process: outputs are checked on every falling edge against the model.
    initial begin : monitor
        logic  aw_hs_p;
        logic  w_hs_p;
        logic  b_hs_p;
        int    rel_cnt;
        int    beats_rem;
        logic  resp_pend;
        desc_t cur_d;
        beat_t b;
        aw_hs_p   = 1'b0;
        w_hs_p    = 1'b0;
        b_hs_p    = 1'b0;
        rel_cnt   = 0;
        beats_rem = 0;
        resp_pend = 1'b0;
        cur_d     = '{id: '0, resp: 2'd0, len: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_awready", awready, 1'b0);
                chk("rst_wready", wready, 1'b0);
                chk("rst_bvalid", bvalid, 1'b0);
                chk("rst_bid", bid, '0);
                chk("rst_bresp", bresp, '0);
                chk("rst_mem_we", mem_we, 1'b0);
                chk("rst_mem_addr", mem_addr, '0);
                chk("rst_mem_wdata", mem_wdata, '0);
                chk("rst_mem_be", mem_be, '0);
                rel_cnt   = 0;
                beats_rem = 0;
                resp_pend = 1'b0;
                beat_q.delete();
                desc_q.delete();
                aw_hs_p = 1'b0;
                w_hs_p  = 1'b0;
                b_hs_p  = 1'b0;
            end else begin
                if (rel_cnt < 2) rel_cnt++;
                if (aw_hs_p) begin
                    chk("aw_desc_avail", desc_q.size() != 0, 1'b1);
                    if (desc_q.size() != 0) begin
                        cur_d     = desc_q.pop_front();
                        beats_rem = cur_d.len + 1;
                    end
                end
                if (w_hs_p) begin
                    chk("beat_expected", (beat_q.size() != 0) && (beats_rem > 0), 1'b1);
                    if (beat_q.size() != 0) begin
                        b = beat_q.pop_front();
                        chk("mem_we", mem_we, b.we);
                        if (b.we) begin
                            chk("mem_addr", mem_addr, b.addr);
                            chk("mem_wdata", mem_wdata, b.data);
                            chk("mem_be", mem_be, b.be);
                        end
                    end
                    if (beats_rem > 0) begin
                        beats_rem--;
                        if (beats_rem == 0) resp_pend = 1'b1;
                    end
                end else begin
                    chk("mem_we_idle", mem_we, 1'b0);
                end
                if (b_hs_p) resp_pend = 1'b0;
                chk("awready", awready, (rel_cnt >= 2) && (beats_rem == 0) && !resp_pend);
                chk("wready", wready, beats_rem > 0);
                chk("bvalid", bvalid, resp_pend);
                if (resp_pend) begin
                    chk("bid", bid, cur_d.id);
                    chk("bresp", bresp, cur_d.resp);
                end
                aw_hs_p = awvalid && awready;
                w_hs_p  = wvalid && wready;
                b_hs_p  = bvalid && bready;
            end
        end
    end

    initial begin : stimulus
        logic [MAW-1:0] wrap_words [4];
        logic [63:0]    a;
        int             len;
        int             size;
        int             burst;
        int             bad_last;
        wrap_words[0] = 10'd10;
        wrap_words[1] = 10'd11;
        wrap_words[2] = 10'd8;
        wrap_words[3] = 10'd9;

        // Hand-computed points that pin the reference model itself.
        for (int i = 0; i < 4; i++) begin
            chk("pin_incr_word", model_word(64'h100, 3, 5, 1, i), 10'(8 + i));
            chk("pin_wrap_word", model_word(64'h140, 3, 5, 2, i), wrap_words[i]);
        end
        chk("pin_fixed_word", model_word(64'h40, 2, 0, 0, 2), 10'd2);
        chk("pin_err_size", model_err(64'h200, 1, 6, 1), 2'd2);
        chk("pin_err_decode", model_err(64'h8000, 1, 5, 1), 2'd3);
        chk("pin_err_wrap_ok", model_err(64'h140, 3, 5, 2), 2'd0);
        chk("pin_err_wrap_len", model_err(64'h140, 2, 5, 2), 2'd2);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_burst(16'h0012, 64'h100, 3, 5, 1, -1, 0, 1'b0, 0);
        run_burst(16'h0034, 64'h140, 3, 5, 2, -1, 1, 1'b0, 0);
        run_burst(16'h0056, 64'h40, 2, 0, 0, -1, 2, 1'b0, 1);
        run_burst(16'h0078, 64'h200, 1, 6, 1, -1, 1, 1'b0, 0);
        run_burst(16'h009a, 64'h8000, 1, 5, 1, -1, 1, 1'b0, 0);
        run_burst(16'h00bc, 64'h300, 3, 5, 1, 1, 0, 1'b0, 0);
        run_burst(16'h00de, 64'h400, 1, 5, 1, -1, 0, 1'b0, 5);

        // Reset in the middle of a data phase abandons the burst.
        prep_burst(16'h0f0f, 64'h600, 3, 5, 1, -1, 0);
        drive_aw();
        drive_w(0, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_we", mem_we, 1'b0);
        chk("async_rst_wready", wready, 1'b0);
        chk("async_rst_awready", awready, 1'b0);
        chk("async_rst_bvalid", bvalid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("awready_after_release", awready, 1'b1);
        run_burst(16'h1357, 64'h100, 3, 5, 1, -1, 1, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            burst = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
            size  = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, BL));
            if (burst == 2) begin
                len = (1 << $urandom_range(1, 4)) - 1;
                if ($urandom_range(0, 7) == 0) len = 2;
            end else begin
                len = $urandom_range(0, 15);
            end
            a = 64'($urandom_range(0, (1 << (MAW + BL)) - 1));
            if ($urandom_range(0, 7) != 0) a = a & ~((64'd1 << size) - 1);
            if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(MAW + BL, 63));
            bad_last = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
            run_burst(IDW'($urandom), a, len, size, burst, bad_last, 1,
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queues_drained", (beat_q.size() == 0) && (desc_q.size() == 0), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
